via_port_arbiter: RTL and testbench

- Shares one NoC router injection port between NUM_REQ via-style traffic sources attached to the same router node.
- Each source presents an already-formed flit ({src node, dst node, 8-bit id, payload}) with a router destination. The block grants sources round-robin and registers the winner into a one-entry output stage that drives the router.
- Keeps a saturating per-source grant count so testbenches can check fairness and throughput.

---
 rtl/via_pkg.sv | 37 +++
 rtl/via_rr_arbiter.sv | 58 +++++
 rtl/via_port_arbiter.sv | 119 +++++++++++
 tb/tb_via_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/via_pkg.sv
// Shared definitions for the via-port arbiter: flit field layout, id width
// and the output-stage state encoding.
package via_pkg;

    // Width of the flit id field.
    localparam int ID_WIDTH = 8;

    // Flit layout, MSB to LSB: {src node, dst node, id, payload}.
    // The arbiter never looks inside a flit. These helpers exist so that
    // sources and checkers agree on where each field lives.
    function automatic int src_lsb(input int width, input int addr_w);
        return width - addr_w;
    endfunction

    function automatic int dst_lsb(input int width, input int addr_w);
        return width - 2 * addr_w;
    endfunction

    function automatic int id_lsb(input int width, input int addr_w);
        return width - 2 * addr_w - ID_WIDTH;
    endfunction

    function automatic int data_lsb();
        return 0;
    endfunction

    function automatic int data_width(input int width, input int addr_w);
        return width - 2 * addr_w - ID_WIDTH;
    endfunction

    // Occupancy of the one-entry output stage.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/via_rr_arbiter.sv
// Rotating-priority arbiter. It produces a one-hot grant, searching from
// rr_ptr upward with wraparound. The pointer moves to the slot just past
// the winner, and only when the owner tells it a grant was taken.
module via_rr_arbiter
    import via_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_enable,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx
);

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_grant_idx;
    logic               w_found;

    // Pick the first valid requester at or after the pointer, modulo NUM_REQ.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = int'(r_rr_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!w_found && i_req[k]) begin
                w_found     = 1'b1;
                w_grant[k]  = 1'b1;
                w_grant_idx = PTR_W'(k);
            end
        end
        if (!i_enable) begin
            w_grant = '0;
        end
    end

    // Move the pointer past the winner. Without a grant, the pointer holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (i_advance) begin
            r_rr_ptr <= (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_grant_idx;

endmodule

// File: rtl/via_port_arbiter.sv
// Shares one router injection port between NUM_REQ flit sources.
// A round-robin grant loads the winner into a one-entry output register.
// A held flit can drain and be refilled on the same edge, so the port
// sustains one flit per cycle. Each source has a saturating accepted-flit
// counter.
module via_port_arbiter
    import via_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*WIDTH-1:0]        req_data_in,
    input  logic [NUM_REQ*N_ADDR_WIDTH-1:0] req_dest_in,
    input  logic [NUM_REQ-1:0]              req_valid_in,
    output logic [NUM_REQ-1:0]              req_ready_out,
    output logic [WIDTH-1:0]                noc_data_out,
    output logic [N_ADDR_WIDTH-1:0]         noc_dest_out,
    output logic                            noc_valid_out,
    input  logic                            noc_ready_in,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    grant_count_out,
    output logic                            busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    out_state_e              r_state;
    logic [WIDTH-1:0]        r_noc_data;
    logic [N_ADDR_WIDTH-1:0] r_noc_dest;

    logic                    w_accept_ok;
    logic                    w_arb_enable;
    logic [NUM_REQ-1:0]      w_grant;
    logic [PTR_W-1:0]        w_grant_idx;
    logic                    w_grant_any;
    logic [WIDTH-1:0]        w_sel_data;
    logic [N_ADDR_WIDTH-1:0] w_sel_dest;

    // The stage can take a flit when it is empty or is draining this cycle.
    // While reset is held, no source sees a grant.
    assign w_accept_ok  = (r_state == EMPTY) || noc_ready_in;
    assign w_arb_enable = w_accept_ok && !rst;
    assign w_grant_any  = |w_grant;

    via_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req_valid_in),
        .i_enable    (w_arb_enable),
        .i_advance   (w_grant_any),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Steer the winning source's flit and destination toward the output register.
    always_comb begin
        w_sel_data = req_data_in[int'(w_grant_idx) * WIDTH +: WIDTH];
        w_sel_dest = req_dest_in[int'(w_grant_idx) * N_ADDR_WIDTH +: N_ADDR_WIDTH];
    end

    // Output-stage FSM: load on a grant, drain to EMPTY when accepted without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_noc_data <= '0;
            r_noc_dest <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_grant_any) begin
                        r_state    <= FULL;
                        r_noc_data <= w_sel_data;
                        r_noc_dest <= w_sel_dest;
                    end
                end
                FULL: begin
                    if (w_grant_any) begin
                        // A grant here implies the router took the old flit this cycle.
                        r_noc_data <= w_sel_data;
                        r_noc_dest <= w_sel_dest;
                    end else if (noc_ready_in) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    // Per-source saturating counters of accepted flits.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        logic [CNT_WIDTH-1:0] r_cnt;

        // Count this source's grants and stick at all-ones.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_grant[gi] && (r_cnt != {CNT_WIDTH{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign grant_count_out[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    end

    assign req_ready_out = w_grant;
    assign noc_data_out  = r_noc_data;
    assign noc_dest_out  = r_noc_dest;
    assign noc_valid_out = (r_state == FULL);
    assign busy          = noc_valid_out || (|req_valid_in);

endmodule

// File: tb/tb_via_port_arbiter.sv
// Bench for via_port_arbiter. A cycle model predicts grants and outputs.
// Every granted flit is pushed to a scoreboard queue and checked when the
// router accepts it.
module tb_via_port_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int AW = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NR*W-1:0]      req_data_in;
    logic [NR*AW-1:0]     req_dest_in;
    logic [NR-1:0]        req_valid_in;
    logic [NR-1:0]        req_ready_out;
    logic [W-1:0]         noc_data_out;
    logic [AW-1:0]        noc_dest_out;
    logic                 noc_valid_out;
    logic                 noc_ready_in;
    logic [NR*CW-1:0]     grant_count_out;
    logic                 busy;

    logic [W-1:0]  d  [NR];
    logic [AW-1:0] ds [NR];

    for (genvar gi = 0; gi < NR; gi++) begin : g_pack
        assign req_data_in[gi*W +: W]   = d[gi];
        assign req_dest_in[gi*AW +: AW] = ds[gi];
    end

    via_port_arbiter #(
        .NUM_REQ   (NR),
        .WIDTH     (W),
        .N         (16),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_data_in     (req_data_in),
        .req_dest_in     (req_dest_in),
        .req_valid_in    (req_valid_in),
        .req_ready_out   (req_ready_out),
        .noc_data_out    (noc_data_out),
        .noc_dest_out    (noc_dest_out),
        .noc_valid_out   (noc_valid_out),
        .noc_ready_in    (noc_ready_in),
        .grant_count_out (grant_count_out),
        .busy            (busy)
    );

    // Reference state.
    bit            m_valid;
    logic [W-1:0]  m_data;
    logic [AW-1:0] m_dest;
    int            m_ptr;
    int            m_cnt [NR];
    logic [W+AW-1:0] sb [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] get_cnt(input int k);
        return grant_count_out[k*CW +: CW];
    endfunction

    function automatic logic [NR-1:0] exp_grant();
        logic [NR-1:0] g;
        g = '0;
        if (rst || !(!m_valid || noc_ready_in)) return g;
        for (int i = 0; i < NR; i++) begin
            int k;
            k = (m_ptr + i) % NR;
            if (req_valid_in[k]) begin
                g[k] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_dest  = '0;
        m_ptr   = 0;
        for (int k = 0; k < NR; k++) m_cnt[k] = 0;
        sb.delete();
    endtask

    // One clock: check at the falling edge, then advance the model at the
    // rising edge and check the registered results just after it.
    task automatic cycle();
        logic [NR-1:0]   eg;
        logic [W+AW-1:0] e;
        @(negedge clk);
        eg = exp_grant();
        check_val("grant", req_ready_out, eg);
        check_val("noc_valid", noc_valid_out, m_valid);
        check_val("busy", busy, m_valid || (|req_valid_in));
        for (int k = 0; k < NR; k++)
            check_val($sformatf("cnt%0d", k), get_cnt(k), m_cnt[k]);
        if (noc_valid_out && noc_ready_in) begin
            if (sb.size() == 0) begin
                check_val("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("xfer_data", noc_data_out, e[W+AW-1:AW]);
                check_val("xfer_dest", noc_dest_out, e[AW-1:0]);
                $display("xfer data=%h dest=%0d", noc_data_out, noc_dest_out);
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (eg != '0) begin
            for (int k = 0; k < NR; k++) begin
                if (eg[k]) begin
                    m_valid = 1'b1;
                    m_data  = d[k];
                    m_dest  = ds[k];
                    sb.push_back({d[k], ds[k]});
                    m_ptr   = (k + 1) % NR;
                    if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
                end
            end
        end else if (m_valid && noc_ready_in) begin
            m_valid = 1'b0;
        end
        #1;
        if (m_valid) begin
            check_val("reg_data", noc_data_out, m_data);
            check_val("reg_dest", noc_dest_out, m_dest);
        end
        if (rst) begin
            check_val("rst_data", noc_data_out, 0);
            check_val("rst_dest", noc_dest_out, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic rand_data();
        for (int k = 0; k < NR; k++) begin
            d[k]  = $urandom;
            ds[k] = AW'($urandom_range(0, 15));
        end
    endtask

    logic [W-1:0] x_hold;

    initial begin
        rst          = 1'b1;
        req_valid_in = '0;
        noc_ready_in = 1'b0;
        for (int k = 0; k < NR; k++) begin
            d[k]  = '0;
            ds[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // While reset is held, no grant appears even with every source valid.
        req_valid_in = 4'hF;
        noc_ready_in = 1'b1;
        cycle();
        check_val("rst_valid", noc_valid_out, 0);
        rst = 1'b0;
        req_valid_in = '0;

        // A single source gets its flit out one cycle after its grant.
        d[0] = 32'h0000_000A;
        ds[0] = 4'd3;
        req_valid_in = 4'b0001;
        cycle();
        check_val("t1_valid", noc_valid_out, 1);
        check_val("t1_data", noc_data_out, 32'hA);
        check_val("t1_dest", noc_dest_out, 3);
        check_val("t1_cnt0", get_cnt(0), 1);
        req_valid_in = '0;
        cycle();

        // With every source valid, grants rotate 0,1,2,3,... at one per cycle.
        do_reset();
        req_valid_in = 4'hF;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            cycle();
            check_val("t2_order", noc_data_out, d[i % NR]);
            check_val("t2_valid", noc_valid_out, 1);
        end
        for (int k = 0; k < NR; k++)
            check_val("t2_cnt", get_cnt(k), 2);

        // Under backpressure the held flit stays stable; on release it drains
        // and the next winner loads on the same edge.
        noc_ready_in = 1'b0;
        x_hold = noc_data_out;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            cycle();
            check_val("t3_hold", noc_data_out, x_hold);
        end
        noc_ready_in = 1'b1;
        cycle();
        check_val("t3_next", noc_data_out, d[0]);

        // The search skips invalid sources and wraps past the top index.
        do_reset();
        rand_data();
        req_valid_in = 4'b0010;
        cycle();
        req_valid_in = 4'b1001;
        cycle();
        check_val("t4_first", noc_data_out, d[3]);
        cycle();
        check_val("t4_second", noc_data_out, d[0]);
        req_valid_in = 4'hF;
        cycle();
        check_val("t4_ptr", noc_data_out, d[1]);

        // Reset mid-stream drops the held flit and clears the counters.
        noc_ready_in = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check_val("t5_valid", noc_valid_out, 0);
        check_val("t5_cnt1", get_cnt(1), 0);
        rst = 1'b0;
        req_valid_in = 4'b0110;
        noc_ready_in = 1'b1;
        cycle();
        check_val("t5_first", noc_data_out, d[1]);

        // The counters saturate at all-ones.
        do_reset();
        req_valid_in = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            cycle();
            if (i == 14) check_val("t6_cnt_at15", get_cnt(0), 15);
        end
        check_val("t6_cnt_sat", get_cnt(0), 15);

        // Random traffic with random backpressure.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            rand_data();
            req_valid_in = NR'($urandom);
            noc_ready_in = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid_in = '0;
        noc_ready_in = 1'b1;
        cycle();
        cycle();
        check_val("drain_sb", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
